// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: CPU (port 0) and loader/DMA (port 1) share one
// single-ported memory with round-robin arbitration and bounded lock tenures.
module mem_arbiter #(
  parameter int LOCK_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
  input  logic [9:0]  wdata0,
  input  logic [9:0]  wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [9:0]  rdata,
  output logic [13:0] mem_addr,
  output logic [9:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [9:0]  mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  // lock_cnt holds grants already issued in the tenure; the grant that would
  // reach LOCK_MAX is the last one and forces release.
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);
  localparam logic CAN_LOCK = (LOCK_MAX > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rvalid0_q, rvalid1_q;
  logic          gnt0_s, gnt1_s;

  // Same-cycle grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            gnt0_s = ~rr_q;
            gnt1_s = rr_q;
          end else begin
            gnt0_s = req0;
            gnt1_s = req1;
          end
        end
        LOCK0:   gnt0_s = req0;
        LOCK1:   gnt1_s = req1;
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Next-state, round-robin pointer and lock tenure bookkeeping.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt0_s) begin
      rr_d = 1'b1;
    end else if (gnt1_s) begin
      rr_d = 1'b0;
    end else begin
      rr_d = rr_q;
    end
    case (state_q)
      IDLE: begin
        if (gnt0_s && lock0 && CAN_LOCK) begin
          state_d    = LOCK0;
          lock_cnt_d = CW'(1);
        end else if (gnt1_s && lock1 && CAN_LOCK) begin
          state_d    = LOCK1;
          lock_cnt_d = CW'(1);
        end else begin
          lock_cnt_d = '0;
        end
      end
      LOCK0: begin
        if (!req0) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          rr_d       = 1'b1;
        end else if (lock0 && (lock_cnt_q < CNT_LAST)) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      LOCK1: begin
        if (!req1) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          rr_d       = 1'b0;
        end else if (lock1 && (lock_cnt_q < CNT_LAST)) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // State registers; a reset mid-read drops the pending rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= gnt0_s & ~we0;
      rvalid1_q  <= gnt1_s & ~we1;
    end
  end

  assign gnt0      = gnt0_s;
  assign gnt1      = gnt1_s;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = mem_rdata;
  assign mem_read  = (gnt0_s & ~we0) | (gnt1_s & ~we1);
  assign mem_write = (gnt0_s & we0) | (gnt1_s & we1);
  assign mem_addr  = gnt0_s ? addr0 : (gnt1_s ? addr1 : 14'h0000);
  assign mem_wdata = gnt0_s ? wdata0 : (gnt1_s ? wdata1 : 10'h000);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle grant/strobe checks plus a
// scoreboard of expected read returns.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [13:0] addr0, addr1;
  logic [9:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [9:0]  rdata, mem_wdata, mem_rdata;
  logic [13:0] mem_addr;
  logic        mem_read, mem_write;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] rv;
    logic [9:0] data;
  } exp_t;
  exp_t sb_q[$];

  mem_arbiter #(.LOCK_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mem_val(input logic [13:0] a);
    return a[9:0] ^ 10'h2A5 ^ {6'b000000, a[13:10]};
  endfunction

  // Memory model: read data one cycle after mem_read.
  initial mem_rdata = 10'h000;
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem_val(mem_addr);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle against the expected grants, then advances to the next negedge.
  task automatic step(input logic eg0, input logic eg1, input string tag);
    logic        er, ew;
    logic [13:0] ea;
    logic [9:0]  ed;
    exp_t        e;
    #1;
    er = (eg0 & ~we0) | (eg1 & ~we1);
    ew = (eg0 & we0) | (eg1 & we1);
    ea = eg0 ? addr0 : (eg1 ? addr1 : 14'h0000);
    ed = eg0 ? wdata0 : (eg1 ? wdata1 : 10'h000);
    check_val({tag, " gnt"}, {30'd0, gnt1, gnt0}, {30'd0, eg1, eg0});
    check_val({tag, " strobes"}, {30'd0, mem_read, mem_write}, {30'd0, er, ew});
    check_val({tag, " mem_addr"}, {18'd0, mem_addr}, {18'd0, ea});
    check_val({tag, " mem_wdata"}, {22'd0, mem_wdata}, {22'd0, ed});
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, " rvalid"}, {30'd0, rvalid1, rvalid0}, {30'd0, e.rv});
      check_val({tag, " rdata"}, {22'd0, rdata}, {22'd0, e.data});
    end else begin
      check_val({tag, " rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
    end
    if (eg0 && !we0) sb_q.push_back('{2'b01, mem_val(addr0)});
    if (eg1 && !we1) sb_q.push_back('{2'b10, mem_val(addr1)});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 14'h0000; addr1 = 14'h0000;
    wdata0 = 10'h000; wdata1 = 10'h000;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    req0 = 1'b1;
    sb_q.delete();
    step(1'b0, 1'b0, "reset");
    rst = 1'b0;
    req0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    do_reset();

    // Single CPU read with next-cycle return
    req0 = 1'b1; addr0 = 14'h2000;
    step(1'b1, 1'b0, "t1_read");
    req0 = 1'b0;
    step(1'b0, 1'b0, "t1_ret");

    // Contested unlocked reads alternate starting with port 0
    do_reset();
    req0 = 1'b1; addr0 = 14'h0AAA;
    req1 = 1'b1; addr1 = 14'h1555;
    step(1'b1, 1'b0, "t2_c1");
    step(1'b0, 1'b1, "t2_c2");
    step(1'b1, 1'b0, "t2_c3");
    step(1'b0, 1'b1, "t2_c4");
    req0 = 1'b0; req1 = 1'b0;
    step(1'b0, 1'b0, "t2_drain");

    // Locked 3-word fetch holds off port 1
    req0 = 1'b1; lock0 = 1'b1; addr0 = 14'h2000;
    req1 = 1'b1; addr1 = 14'h0100;
    step(1'b1, 1'b0, "t3_c1");
    addr0 = 14'h2001;
    step(1'b1, 1'b0, "t3_c2");
    addr0 = 14'h2002;
    step(1'b1, 1'b0, "t3_c3");
    req0 = 1'b0; lock0 = 1'b0;
    step(1'b0, 1'b1, "t3_c4");
    req1 = 1'b0;
    step(1'b0, 1'b0, "t3_drain");

    // Lock held beyond LOCK_MAX is forcibly released
    req0 = 1'b1; lock0 = 1'b1; addr0 = 14'h0300;
    req1 = 1'b1; addr1 = 14'h0400;
    step(1'b1, 1'b0, "t4_c1");
    addr0 = 14'h0301;
    step(1'b1, 1'b0, "t4_c2");
    addr0 = 14'h0302;
    step(1'b1, 1'b0, "t4_c3");
    addr0 = 14'h0303;
    step(1'b0, 1'b1, "t4_c4");
    req1 = 1'b0;
    step(1'b1, 1'b0, "t4_c5");
    addr0 = 14'h0304;
    step(1'b1, 1'b0, "t4_c6");
    req0 = 1'b0; lock0 = 1'b0;
    step(1'b0, 1'b0, "t4_release");

    // Locked write from port 1, released by dropping req1
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 14'h0010; wdata1 = 10'h3FF;
    step(1'b0, 1'b1, "t5_write");
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    step(1'b0, 1'b0, "t5_drop");
    req0 = 1'b1; addr0 = 14'h0200;
    step(1'b1, 1'b0, "t5_idle");
    req0 = 1'b0;
    step(1'b0, 1'b0, "t5_drain");

    // Reset while a read is in flight
    req0 = 1'b1; addr0 = 14'h0123;
    #1;
    check_val("t6 gnt0", {31'd0, gnt0}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6 rst gnt", {30'd0, gnt1, gnt0}, 32'd0);
    check_val("t6 rst strobes", {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    check_val("t6 rst rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    sb_q.delete();
    rst = 1'b0;
    req0 = 1'b1; addr0 = 14'h0050;
    req1 = 1'b1; addr1 = 14'h0060;
    step(1'b1, 1'b0, "t6_after");
    req0 = 1'b0;
    step(1'b0, 1'b1, "t6_p1");
    req1 = 1'b0;
    step(1'b0, 1'b0, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 3: maximum granted accesses per lock tenure (one 3-word instruction fetch).
REQ-002 clk  input  1  clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req0, req1  input  1 each  access request, port 0 (CPU) and port 1 (loader/DMA).
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; qualified by req.
REQ-006 addr0, addr1  input  14 each  word address.
REQ-007 wdata0, wdata1  input  10 each  write data.
REQ-008 lock0, lock1  input  1 each  hold ownership after this access.
REQ-009 gnt0, gnt1  output  1 each  access issued to memory this cycle.
REQ-010 rvalid0, rvalid1  output  1 each  read data valid on rdata this cycle.
REQ-011 rdata  output  10  read data; mirrors mem_rdata.
REQ-012 mem_addr  output  14  memory address.
REQ-013 mem_wdata  output  10  memory write data.
REQ-014 mem_read, mem_write  output  1 each  memory strobes.
REQ-015 mem_rdata  input  10  memory read data; valid the cycle after mem_read.

Function
REQ-016 The block SHALL issue at most one memory access per cycle; gnt0 and gnt1 SHALL never both be 1.
REQ-017 Grant SHALL be combinational: gnt_i=1 in the same cycle req_i is high and port i wins arbitration.
REQ-018 When gnt_i=1: mem_addr=addr_i, mem_wdata=wdata_i, mem_read=~we_i, mem_write=we_i; with no grant, both strobes 0 and mem_addr/mem_wdata 0.
REQ-019 rvalid_i SHALL be 1 exactly one cycle after a granted read from port i; rdata=mem_rdata at all times.
REQ-020 Requesters hold req/we/addr/wdata/lock stable until gnt; the arbiter does not check this.
REQ-021 FSM states: IDLE, LOCK0, LOCK1.
REQ-022 IDLE, single requester: that port granted.
REQ-023 IDLE, both requesting: port indicated by 1-bit round-robin pointer rr granted; rr points to port 0 after reset.
REQ-024 After any grant to port i, rr SHALL point to the other port on the next cycle.
REQ-025 IDLE -> LOCKi when gnt_i and lock_i; lock_cnt set to 1.
REQ-026 LOCKi: only port i may be granted; the other port's request waits, gnt stays 0 for it.
REQ-027 LOCKi, gnt_i with lock_i=1 and lock_cnt<LOCK_MAX: remain, lock_cnt+1.
REQ-028 LOCKi -> IDLE when: gnt_i with lock_i=0; or req_i=0 for one cycle; or gnt_i with lock_cnt=LOCK_MAX (forced release, regardless of lock_i).
REQ-029 On transition to IDLE, rr SHALL point to the other port, so a waiting requester wins the next contested cycle.
REQ-030 lock_cnt width SHALL be clog2(LOCK_MAX+1); no wrap.
REQ-031 Simultaneous req in LOCKi cycle where release occurs: grant still goes only to port i in that cycle; other port served earliest next cycle.

Reset
REQ-032 On rst: state=IDLE, rr=port 0, lock_cnt=0, rvalid0=rvalid1=0; gnt/mem strobes follow REQ-018 (0 with no request).
REQ-033 Reset asserted with a read outstanding SHALL suppress its rvalid; no rvalid on the first cycle after reset release.
REQ-034 While rst=1, gnt0, gnt1, mem_read, mem_write SHALL be 0.

Verification
REQ-035 req0 read addr 0x2000, idle -> same-cycle gnt0, mem_read=1, mem_addr=0x2000; next cycle rvalid0=1, rdata=mem_rdata.
REQ-036 req0 and req1 both held 4 cycles after reset, no lock -> grants alternate 0,1,0,1.
REQ-037 port 0 lock=1 for 3 reads (0x2000-0x2002), req1 held -> gnt0 three cycles, gnt1 on cycle 4.
REQ-038 port 0 lock=1 held for 5 requests, LOCK_MAX=3, req1 waiting -> forced release after third gnt0, gnt1 next cycle.
REQ-039 port 1 write 0x3FF to 0x0010 with lock=1, then req1 dropped one cycle -> state IDLE, rvalid1 never asserted, mem_write one cycle.
REQ-040 rst asserted the cycle after granted read -> no rvalid; after release req1 and req0 both high -> gnt0 first.
